// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu issue/retire controller: op codes,
// pack-width codes, FSM state encoding and request decode helpers.
package xc_malu_pkg;

    localparam int OP_W   = 4;
    localparam int PW_W   = 3;
    localparam int UOP_W  = 14;
    localparam int PWH_W  = 5;

    localparam logic [OP_W-1:0] OP_DIV    = 4'd0;
    localparam logic [OP_W-1:0] OP_DIVU   = 4'd1;
    localparam logic [OP_W-1:0] OP_REM    = 4'd2;
    localparam logic [OP_W-1:0] OP_REMU   = 4'd3;
    localparam logic [OP_W-1:0] OP_MUL    = 4'd4;
    localparam logic [OP_W-1:0] OP_MULU   = 4'd5;
    localparam logic [OP_W-1:0] OP_MULSU  = 4'd6;
    localparam logic [OP_W-1:0] OP_CLMUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_PMUL   = 4'd8;
    localparam logic [OP_W-1:0] OP_PCLMUL = 4'd9;
    localparam logic [OP_W-1:0] OP_MADD   = 4'd10;
    localparam logic [OP_W-1:0] OP_MSUB   = 4'd11;
    localparam logic [OP_W-1:0] OP_MACC   = 4'd12;
    localparam logic [OP_W-1:0] OP_MMUL   = 4'd13;

    localparam logic [PW_W-1:0] PW_32 = 3'd0;
    localparam logic [PW_W-1:0] PW_16 = 3'd1;
    localparam logic [PW_W-1:0] PW_8  = 3'd2;
    localparam logic [PW_W-1:0] PW_4  = 3'd3;
    localparam logic [PW_W-1:0] PW_2  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the packed multiplies honour a non-32 pack width.
    function automatic logic is_packed_op(input logic [OP_W-1:0] op);
        return (op == OP_PMUL) || (op == OP_PCLMUL);
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op, input logic [PW_W-1:0] pw);
        logic ok;
        if (op > OP_MMUL) begin
            ok = 1'b0;
        end else if (is_packed_op(op)) begin
            ok = (pw <= PW_2);
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Codes 14/15 shift the single bit out of range, giving an all-zero uop.
    function automatic logic [UOP_W-1:0] decode_uop(input logic [OP_W-1:0] op);
        return 14'd1 << op;
    endfunction

    // One-hot {pw_2, pw_4, pw_8, pw_16, pw_32}; non-packed ops always run at 32.
    function automatic logic [PWH_W-1:0] decode_pw(input logic [OP_W-1:0] op, input logic [PW_W-1:0] pw);
        logic [PWH_W-1:0] pwh;
        if (is_packed_op(op) && (pw <= PW_2)) begin
            pwh = 5'd1 << pw;
        end else begin
            pwh = 5'b00001;
        end
        return pwh;
    endfunction

endpackage

// File: rtl/xc_malu_ctrl_lfsr.sv
// 32-bit Galois LFSR producing the xc_malu flush_data pattern.
module xc_malu_ctrl_lfsr #(
    parameter logic [31:0] SEED = 32'hACE1_2468,
    parameter logic [31:0] TAPS = 32'h8020_0003
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        en,
    output logic [31:0] state
);

    logic [31:0] next_s;

    // Right-shift Galois step: feed the dropped LSB back through the tap mask.
    always_comb begin
        next_s = state >> 1;
        if (state[0]) begin
            next_s = next_s ^ TAPS;
        end else begin
            next_s = next_s;
        end
    end

    // State register, reloaded with the non-zero seed on reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= SEED;
        end else if (en) begin
            state <= next_s;
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/xc_malu_ctrl.sv
// Issue/retire controller wrapped around xc_malu: accepts requests, drives
// uop/pw strobes and stable operands, manages flush, and formats results
// for writeback.
module xc_malu_ctrl
    import xc_malu_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              kill,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OP_W-1:0]   s_op,
    input  logic [PW_W-1:0]   s_pw,
    input  logic              s_hi,
    input  logic [4:0]        s_rd,
    input  logic [31:0]       s_rs1,
    input  logic [31:0]       s_rs2,
    input  logic [31:0]       s_rs3,
    output logic [31:0]       m_rs1,
    output logic [31:0]       m_rs2,
    output logic [31:0]       m_rs3,
    output logic              m_valid,
    output logic              m_flush,
    output logic [31:0]       m_flush_data,
    output logic [UOP_W-1:0]  m_uop,
    output logic [PWH_W-1:0]  m_pw,
    input  logic [63:0]       m_result,
    input  logic              m_ready,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [4:0]        w_rd,
    output logic [31:0]       w_data,
    output logic [31:0]       w_data_hi,
    output logic              w_pair,
    output logic              w_err
);

    state_t             state_r, state_nxt_s;
    logic               kill_s, legal_s, accept_s, capture_s;
    logic [31:0]        rs1_r, rs2_r, rs3_r;
    logic [UOP_W-1:0]   uop_r;
    logic [PWH_W-1:0]   pw_r;
    logic [OP_W-1:0]    op_r;
    logic               hi_r;
    logic [4:0]         rd_r;
    logic [31:0]        w_data_r, w_data_hi_r, fmt_data_s, fmt_hi_s;
    logic               w_pair_r, w_err_r, fmt_pair_s;

    // Reset in the middle of an operation aborts it exactly like kill.
    assign kill_s  = kill || !resetn;
    assign legal_s = op_legal(s_op, s_pw);

    // Next-state logic and handshake strobes; kill always wins.
    always_comb begin
        state_nxt_s = state_r;
        s_ready     = 1'b0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                s_ready = !kill_s;
                if (!kill_s && s_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = legal_s ? BUSY : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (kill_s) begin
                    state_nxt_s = IDLE;
                end else if (m_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (kill_s) begin
                    state_nxt_s = IDLE;
                end else if (w_ready) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = legal_s ? BUSY : DONE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Select the architectural result half(s) for the op in flight.
    always_comb begin
        fmt_data_s = m_result[31:0];
        fmt_hi_s   = 32'd0;
        fmt_pair_s = 1'b0;
        case (op_r)
            OP_MUL, OP_MULU, OP_MULSU, OP_CLMUL, OP_PMUL, OP_PCLMUL: begin
                if (hi_r) begin
                    fmt_data_s = m_result[63:32];
                end else begin
                    fmt_data_s = m_result[31:0];
                end
            end
            OP_MADD, OP_MSUB: begin
                fmt_hi_s   = {31'd0, m_result[32]};
                fmt_pair_s = 1'b1;
            end
            OP_MACC, OP_MMUL: begin
                fmt_hi_s   = m_result[63:32];
                fmt_pair_s = 1'b1;
            end
            default: begin
                fmt_data_s = m_result[31:0];
            end
        endcase
    end

    // Request capture at accept and result capture when xc_malu completes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rs1_r       <= 32'd0;
            rs2_r       <= 32'd0;
            rs3_r       <= 32'd0;
            uop_r       <= 14'd0;
            pw_r        <= 5'd0;
            op_r        <= 4'd0;
            hi_r        <= 1'b0;
            rd_r        <= 5'd0;
            w_data_r    <= 32'd0;
            w_data_hi_r <= 32'd0;
            w_pair_r    <= 1'b0;
            w_err_r     <= 1'b0;
        end else if (accept_s) begin
            rs1_r   <= s_rs1;
            rs2_r   <= s_rs2;
            rs3_r   <= s_rs3;
            uop_r   <= legal_s ? decode_uop(s_op) : 14'd0;
            pw_r    <= decode_pw(s_op, s_pw);
            op_r    <= s_op;
            hi_r    <= s_hi;
            rd_r    <= s_rd;
            w_err_r <= !legal_s;
            if (!legal_s) begin
                w_data_r    <= 32'd0;
                w_data_hi_r <= 32'd0;
                w_pair_r    <= 1'b0;
            end
        end else if (capture_s) begin
            w_data_r    <= fmt_data_s;
            w_data_hi_r <= fmt_hi_s;
            w_pair_r    <= fmt_pair_s;
            w_err_r     <= 1'b0;
        end
    end

    xc_malu_ctrl_lfsr #(
        .SEED (LFSR_SEED),
        .TAPS (32'h8020_0003)
    ) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .en     (1'b1),
        .state  (m_flush_data)
    );

    assign m_rs1     = rs1_r;
    assign m_rs2     = rs2_r;
    assign m_rs3     = rs3_r;
    assign m_valid   = (state_r == BUSY);
    assign m_uop     = m_valid ? uop_r : 14'd0;
    assign m_pw      = m_valid ? pw_r : 5'd0;
    assign m_flush   = m_valid && (m_ready || kill_s);
    assign w_valid   = (state_r == DONE);
    assign w_rd      = rd_r;
    assign w_data    = w_data_r;
    assign w_data_hi = w_data_hi_r;
    assign w_pair    = w_pair_r;
    assign w_err     = w_err_r;

endmodule
